color_intensity_solver: RTL and testbench
=========================================

# color_intensity_solver

Inverse of the colour interpolation stage: given the two endpoint colours and a mixed colour, it recovers the 16-bit intensity that blends them, where mixedColor ≈ intensity·colorA + (1 − intensity)·colorB. The block picks the sub-pixel channel with the largest endpoint spread and runs a serial restoring division on it. It sits in the texture/blend verification and readback path, feeding intensity values back into the pixel pipeline. It uses valid/ready handshakes on both sides.

## Interface
- SUB_PIXEL_WIDTH, 8, bits per sub-pixel; four sub-pixels per pixel, so PIXEL_WIDTH = 4·SUB_PIXEL_WIDTH.
- aclk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- s_valid  in  1  input triple valid.
- s_ready  out  1  block can accept a triple; high only in IDLE.
- s_colorA, s_colorB, s_mixedColor  in  PIXEL_WIDTH each  endpoints and mixed colour; sub-pixel i is at bits [i·SUB_PIXEL_WIDTH +: SUB_PIXEL_WIDTH].
- m_valid  out  1  result valid.
- m_ready  in  1  consumer accepts the result.
- m_intensity  out  16  recovered intensity; 0xFFFF = 1.0.
- m_degenerate  out  1  all channels have A == B; intensity is undefined and reported as 0x0000.

## Operation
- State machine: IDLE → SELECT → DIVIDE → DONE → IDLE.
  - IDLE: s_ready = 1. When s_valid is high, register the three colours and go to SELECT.
  - SELECT (1 cycle): per channel, d_i = A_i − B_i and n_i = M_i − B_i, each SUB_PIXEL_WIDTH+1 bits signed. Pick the channel with the largest |d_i|; on a tie, the lowest index wins. If d < 0, negate both d and n.
- Early exits from SELECT straight to DONE:
  - all d_i = 0: m_degenerate = 1, intensity 0x0000.
  - n ≤ 0: intensity 0x0000.
  - n ≥ d: intensity 0xFFFF.
  - Otherwise load the remainder with n and go to DIVIDE.
- DIVIDE: one quotient bit per cycle, MSB first, for 16 cycles.
  - Each cycle: r = 2r; if r ≥ d then r −= d and the bit is 1.
  - Result = floor(n·65536 / d), which is < 0x10000 because n < d.
  - The remainder register is SUB_PIXEL_WIDTH+1 bits wide.
- DONE: m_valid = 1. m_intensity and m_degenerate stay stable until m_valid && m_ready, then return to IDLE. s_ready is low throughout DONE.
- New inputs are accepted only in IDLE. Inputs presented in other states are ignored and not buffered.

## Timing
- Reset values: s_ready = 1, m_valid = 0, m_intensity = 0x0000, m_degenerate = 0, state = IDLE. Reset asserted mid-operation abandons the job with no output.
- Latency from the accept edge to m_valid high:
  - 18 cycles for a normal divide (1 SELECT + 16 DIVIDE + DONE entry).
  - 2 cycles for an early exit.
  - One extra cycle when INTENSITY_ROUND_EN is defined.
- Throughput: at best one result every 19 cycles. The earliest re-accept is the cycle after the output handshake, because IDLE is re-entered first.
- m_ready held high before m_valid rises: the handshake completes on the first DONE cycle.

## Configuration
- RRX_COLOR_INTENSITY_ROUND_EN defined:
  - DIVIDE runs 17 iterations and the 17th bit is added as round-half-up.
  - A result of 0x10000 saturates to 0xFFFF.
- Undefined: 16 iterations, truncated quotient.
- Early-exit behaviour is identical in both builds.

## Structure
- Shared package rrx_color_pkg holds:
  - NUMBER_OF_SUB_PIXEL = 4
  - INTENSITY_ONE = 16'hFFFF
  - the state enum {IDLE, SELECT, DIVIDE, DONE}
- Sub-module intensity_divider is the serial restoring divider.
  - Ports: start, numerator, denominator, busy, done, quotient.
  - It is parameterised by operand width and by iteration count (16 or 17).
- The top level holds the handshake FSM and the channel-select logic.

## Test plan
All cases use SUB_PIXEL_WIDTH = 8.
- A = 0x000000FF, B = 0, M = 0x00000080 → m_intensity 0x8080, m_degenerate 0, m_valid 18 cycles after accept.
- A = 0, B = 0x000000FF, M = 0x0000007F (negative spread) → 0x8080.
- A = 0x00000003, B = 0, M = 0x00000002 → 0xAAAA without rounding, 0xAAAB with RRX_COLOR_INTENSITY_ROUND_EN.
- A = B = 0x12345678, any M → m_degenerate 1, intensity 0x0000, 2-cycle latency. Separately, M = A with A ≠ B → 0xFFFF, 2-cycle latency.
- Tie select: A = 0x00C8C800, B = 0, M = 0x00006400 (channel 1 selected, n = 100, d = 200) → 0x8000. Then hold m_ready low for 5 cycles: outputs stay stable and s_ready stays 0.
- Assert reset at DIVIDE iteration 8 → m_valid 0 and s_ready 1 immediately. A fresh job after release completes correctly.

Source files
------------

// File: rtl/rrx_color_pkg.sv
// Shared constants and state encoding for the colour intensity solver.
// RRX_COLOR_INTENSITY_ROUND_EN adds a guard quotient bit for round-half-up.
package rrx_color_pkg;

    localparam int unsigned NUMBER_OF_SUB_PIXEL = 4;
    localparam logic [15:0] INTENSITY_ONE       = 16'hFFFF;

`ifdef RRX_COLOR_INTENSITY_ROUND_EN
    localparam int unsigned DIV_ITERS = 17;
`else
    localparam int unsigned DIV_ITERS = 16;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        DIVIDE,
        DONE
    } state_e;

endpackage

// File: rtl/intensity_divider.sv
// Serial restoring divider: one quotient bit per cycle, MSB first.
// done is high during the cycle whose clock edge performs the final iteration.
module intensity_divider #(
    parameter int unsigned Width = 9,
    parameter int unsigned Iters = 16
) (
    input  logic             aclk,
    input  logic             reset,
    input  logic             start,
    input  logic [Width-1:0] numerator,
    input  logic [Width-1:0] denominator,
    output logic             busy,
    output logic             done,
    output logic [Iters-1:0] quotient
);

    localparam int unsigned CntW = $clog2(Iters + 1);

    logic [Width-1:0] rem_q, rem_d, den_q;
    logic [Iters-1:0] quot_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;
    logic [Width:0]   rem_shift, rem_diff;
    logic             take;

    // Remainder stays below the denominator, so the doubled value fits in Width+1 bits.
    always_comb begin
        rem_shift = {rem_q, 1'b0};
        rem_diff  = rem_shift - {1'b0, den_q};
        take      = rem_shift >= {1'b0, den_q};
        rem_d     = take ? rem_diff[Width-1:0] : rem_shift[Width-1:0];
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CntW'(Iters - 1));
    assign quotient = quot_q;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            rem_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= numerator;
            den_q  <= denominator;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quot_q <= {quot_q[Iters-2:0], take};
            cnt_q  <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/color_intensity_solver.sv
// Recovers the blend intensity from two endpoint colours and a mixed colour.
// RRX_COLOR_INTENSITY_ROUND_EN selects a rounded instead of a truncated quotient.
module color_intensity_solver
    import rrx_color_pkg::*;
#(
    parameter int unsigned SUB_PIXEL_WIDTH = 8,
    localparam int unsigned PIXEL_WIDTH = NUMBER_OF_SUB_PIXEL * SUB_PIXEL_WIDTH
) (
    input  logic                   aclk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_colorA,
    input  logic [PIXEL_WIDTH-1:0] s_colorB,
    input  logic [PIXEL_WIDTH-1:0] s_mixedColor,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [15:0]            m_intensity,
    output logic                   m_degenerate
);

    localparam int unsigned SPW = SUB_PIXEL_WIDTH;

    state_e                  state_q;
    logic [PIXEL_WIDTH-1:0]  a_q, b_q, m_q;
    logic                    s_ready_q, m_valid_q, m_degen_q, from_div_q;
    logic [15:0]             m_int_q;

    logic signed [SPW:0] diff_d [NUMBER_OF_SUB_PIXEL];
    logic signed [SPW:0] diff_n [NUMBER_OF_SUB_PIXEL];
    logic [SPW:0]        mag    [NUMBER_OF_SUB_PIXEL];
    logic [SPW:0]        best_mag;
    logic signed [SPW:0] sel_d, sel_n;
    logic                degenerate, n_nonpos, n_full;

    always_comb begin
        for (int i = 0; i < NUMBER_OF_SUB_PIXEL; i++) begin
            diff_d[i] = $signed({1'b0, a_q[i*SPW +: SPW]}) - $signed({1'b0, b_q[i*SPW +: SPW]});
            diff_n[i] = $signed({1'b0, m_q[i*SPW +: SPW]}) - $signed({1'b0, b_q[i*SPW +: SPW]});
            mag[i]    = diff_d[i][SPW] ? $unsigned(-diff_d[i]) : $unsigned(diff_d[i]);
        end
        sel_d    = diff_d[0];
        sel_n    = diff_n[0];
        best_mag = mag[0];
        // Strict compare keeps the lowest index on a tie.
        for (int i = 1; i < NUMBER_OF_SUB_PIXEL; i++) begin
            if (mag[i] > best_mag) begin
                best_mag = mag[i];
                sel_d    = diff_d[i];
                sel_n    = diff_n[i];
            end
        end
        if (sel_d < 0) begin
            sel_d = -sel_d;
            sel_n = -sel_n;
        end
        degenerate = (best_mag == '0);
        n_nonpos   = (sel_n <= 0);
        n_full     = (sel_n >= sel_d);
    end

    logic                 div_start, div_busy, div_done;
    logic [DIV_ITERS-1:0] div_quotient;
    logic [15:0]          div_result;

    assign div_start = (state_q == SELECT) && !degenerate && !n_nonpos && !n_full && !div_busy;

    intensity_divider #(
        .Width (SPW + 1),
        .Iters (DIV_ITERS)
    ) u_divider (
        .aclk        (aclk),
        .reset       (reset),
        .start       (div_start),
        .numerator   ($unsigned(sel_n)),
        .denominator ($unsigned(sel_d)),
        .busy        (div_busy),
        .done        (div_done),
        .quotient    (div_quotient)
    );

`ifdef RRX_COLOR_INTENSITY_ROUND_EN
    logic [16:0] rounded;
    assign rounded    = {1'b0, div_quotient[16:1]} + 17'(div_quotient[0]);
    assign div_result = rounded[16] ? INTENSITY_ONE : rounded[15:0];
`else
    assign div_result = div_quotient;
`endif

    assign s_ready      = s_ready_q;
    assign m_valid      = m_valid_q;
    assign m_degenerate = m_degen_q;
    // The divider's quotient register holds still once it finishes, so it is read directly.
    assign m_intensity  = from_div_q ? div_result : m_int_q;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            m_q        <= '0;
            s_ready_q  <= 1'b1;
            m_valid_q  <= 1'b0;
            m_degen_q  <= 1'b0;
            m_int_q    <= '0;
            from_div_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        a_q       <= s_colorA;
                        b_q       <= s_colorB;
                        m_q       <= s_mixedColor;
                        s_ready_q <= 1'b0;
                        state_q   <= SELECT;
                    end
                end
                SELECT: begin
                    from_div_q <= 1'b0;
                    m_degen_q  <= degenerate;
                    m_int_q    <= (!degenerate && !n_nonpos && n_full) ? INTENSITY_ONE : 16'h0000;
                    if (degenerate || n_nonpos || n_full) begin
                        m_valid_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        state_q   <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        from_div_q <= 1'b1;
                        m_valid_q  <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_color_intensity_solver.sv
// Directed and random checks of color_intensity_solver against an arithmetic model.
// Honours RRX_COLOR_INTENSITY_ROUND_EN the same way as the design.
module tb_color_intensity_solver;

    localparam int PW = 32;

    logic          aclk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [PW-1:0] s_colorA = '0, s_colorB = '0, s_mixedColor = '0;
    logic          s_ready, m_valid, m_degenerate;
    logic [15:0]   m_intensity;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    color_intensity_solver #(.SUB_PIXEL_WIDTH(8)) dut (
        .aclk         (aclk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_colorA     (s_colorA),
        .s_colorB     (s_colorB),
        .s_mixedColor (s_mixedColor),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_intensity  (m_intensity),
        .m_degenerate (m_degenerate)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Intensity as n*65536/d on the widest-spread channel; latency counts SELECT as cycle 1.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] m, output logic [15:0] q,
                                  output logic dg, output int lat);
        int     best, bi, d, n;
        longint t;
        best = -1;
        bi   = 0;
        for (int i = 0; i < 4; i++) begin
            int di;
            di = int'(a[8*i +: 8]) - int'(b[8*i +: 8]);
            if ((di < 0 ? -di : di) > best) begin
                best = (di < 0) ? -di : di;
                bi   = i;
            end
        end
        d = int'(a[8*bi +: 8]) - int'(b[8*bi +: 8]);
        n = int'(m[8*bi +: 8]) - int'(b[8*bi +: 8]);
        if (d < 0) begin
            d = -d;
            n = -n;
        end
        dg  = 1'b0;
        lat = 2;
        if (d == 0) begin
            dg = 1'b1;
            q  = 16'h0000;
        end else if (n <= 0) begin
            q = 16'h0000;
        end else if (n >= d) begin
            q = 16'hFFFF;
        end else begin
`ifdef RRX_COLOR_INTENSITY_ROUND_EN
            lat = 19;
            t   = (longint'(n) * 131072) / d;
            t   = (t + 1) / 2;
            if (t > 65535) t = 65535;
`else
            lat = 18;
            t   = (longint'(n) * 65536) / d;
`endif
            q = 16'(t);
        end
    endfunction

    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] m,
                           input string tag, input int hold);
        logic [15:0] eq;
        logic        ed;
        int          el, lat, k;
        model(a, b, m, eq, ed, el);
        k = 0;
        while (s_ready !== 1'b1 && k < 50) begin
            @(posedge aclk); #1;
            k++;
        end
        check({tag, "_sready_idle"}, 32'(s_ready), 32'd1);
        s_colorA     = a;
        s_colorB     = b;
        s_mixedColor = m;
        s_valid      = 1'b1;
        m_ready      = (hold == 0);
        @(posedge aclk); #1;
        s_valid      = 1'b0;
        s_colorA     = $urandom;
        s_colorB     = $urandom;
        s_mixedColor = $urandom;
        lat = 1;
        while (m_valid !== 1'b1 && lat < 60) begin
            @(posedge aclk); #1;
            lat++;
        end
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(el));
        check({tag, "_intensity"}, 32'(m_intensity), 32'(eq));
        check({tag, "_degenerate"}, 32'(m_degenerate), 32'(ed));
        for (int h = 0; h < hold; h++) begin
            @(posedge aclk); #1;
            check({tag, "_hold_valid"}, 32'(m_valid), 32'd1);
            check({tag, "_hold_intensity"}, 32'(m_intensity), 32'(eq));
            check({tag, "_hold_degenerate"}, 32'(m_degenerate), 32'(ed));
            check({tag, "_hold_sready"}, 32'(s_ready), 32'd0);
        end
        m_ready = 1'b1;
        @(posedge aclk); #1;
        m_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_post_sready"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a, b, m;
        int          lo, hi;

        repeat (3) @(posedge aclk);
        #1;
        check("reset_sready", 32'(s_ready), 32'd1);
        check("reset_mvalid", 32'(m_valid), 32'd0);
        check("reset_intensity", 32'(m_intensity), 32'd0);
        check("reset_degenerate", 32'(m_degenerate), 32'd0);
        reset = 1'b0;
        @(posedge aclk); #1;

        run_job(32'h000000FF, 32'h00000000, 32'h00000080, "half", 0);
        run_job(32'h00000000, 32'h000000FF, 32'h0000007F, "neg_spread", 0);
        run_job(32'h00000003, 32'h00000000, 32'h00000002, "two_thirds", 0);
        run_job(32'h12345678, 32'h12345678, 32'h9ABCDEF0, "degenerate", 0);
        run_job(32'h00C0FFEE, 32'h00000000, 32'h00C0FFEE, "m_eq_a", 0);
        run_job(32'h000000FF, 32'h00000080, 32'h00000010, "n_negative", 0);
        run_job(32'h00C8C800, 32'h00000000, 32'h00006400, "tie_hold", 5);

        // Reset during the eighth divide iteration abandons the job at once.
        s_colorA     = 32'h000000FF;
        s_colorB     = 32'h00000000;
        s_mixedColor = 32'h00000080;
        s_valid      = 1'b1;
        @(posedge aclk); #1;
        s_valid = 1'b0;
        repeat (8) @(posedge aclk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_mvalid", 32'(m_valid), 32'd0);
        check("midreset_sready", 32'(s_ready), 32'd1);
        check("midreset_intensity", 32'(m_intensity), 32'd0);
        @(posedge aclk); #1;
        reset = 1'b0;
        run_job(32'h00000003, 32'h00000000, 32'h00000002, "after_reset", 0);

        for (int j = 0; j < 40; j++) begin
            a = $urandom;
            b = $urandom;
            m = $urandom;
            if (j % 2 == 0) begin
                for (int i = 0; i < 4; i++) begin
                    lo = (a[8*i +: 8] < b[8*i +: 8]) ? int'(a[8*i +: 8]) : int'(b[8*i +: 8]);
                    hi = (a[8*i +: 8] < b[8*i +: 8]) ? int'(b[8*i +: 8]) : int'(a[8*i +: 8]);
                    m[8*i +: 8] = 8'($urandom_range(hi, lo));
                end
            end
            run_job(a, b, m, "random", (j % 4 == 1) ? 2 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
